// File: rtl/core_pkg.sv
// Shared owner encoding and default widths for the memory port arbiter.
package core_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE  = 2'd0;
    localparam owner_t OWN_FETCH = 2'd1;
    localparam owner_t OWN_DATA  = 2'd2;

    // Map a one-hot grant vector (bit0 fetch, bit1 data) to its owner code.
    function automatic owner_t owner_of(input logic [1:0] gnt);
        if (gnt[1]) begin
            return OWN_DATA;
        end else if (gnt[0]) begin
            return OWN_FETCH;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: bit0 = fetch, bit1 = data. Lock restricts
// the choice to the data side; a tie goes to whichever side did not win last.
module rr_pick2
    import core_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last,
    input  logic       i_lock,
    output logic [1:0] o_gnt_c
);

    // Select at most one requester.
    always_comb begin
        o_gnt_c = 2'b00;
        if (i_lock) begin
            o_gnt_c = {i_req[1], 1'b0};
        end else begin
            case (i_req)
                2'b01:   o_gnt_c = 2'b01;
                2'b10:   o_gnt_c = 2'b10;
                2'b11:   o_gnt_c = (i_last == OWN_FETCH) ? 2'b10 : 2'b01;
                default: o_gnt_c = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// load/store. Grants are same-cycle; responses return one cycle later to the
// owner recorded at grant time. The data side may lock the port across RMW.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic                d_lock,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_en,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata
);

    owner_t     r_last_owner;
    owner_t     r_resp_owner;
    logic       r_lock_held;
    logic [1:0] w_pick;
    logic [1:0] w_gnt;

    rr_pick2 u_pick (
        .i_req   ({d_req, i_req}),
        .i_last  (r_last_owner),
        .i_lock  (r_lock_held),
        .o_gnt_c (w_pick)
    );

    // No grant may escape while reset is asserted.
    assign w_gnt = w_pick & {2{rst}};
    assign i_gnt = w_gnt[0];
    assign d_gnt = w_gnt[1];

    // Steer the granted requester onto the memory port; idle port is all zero.
    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (w_gnt[1]) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (w_gnt[0]) begin
            m_en    = 1'b1;
            m_be    = '1;
            m_addr  = i_addr;
        end
    end

    // Track fairness history, lock ownership and who receives next response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_owner <= OWN_FETCH;
            r_lock_held  <= 1'b0;
            r_resp_owner <= OWN_NONE;
        end else begin
            r_resp_owner <= owner_of(w_gnt);
            if (|w_gnt) begin
                r_last_owner <= owner_of(w_gnt);
            end
            if (w_gnt[1]) begin
                r_lock_held <= d_lock;
            end
        end
    end

    assign i_rvalid = (r_resp_owner == OWN_FETCH);
    assign d_rvalid = (r_resp_owner == OWN_DATA);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_lock;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [3:0]  m_be;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] mem [0:65535];

    mem_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_lock   (d_lock),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory; preset contents reload whenever reset is sampled low.
    always @(posedge clk) begin
        if (!rst) begin
            mem[16'h0010] <= 32'h0000_0013;
            mem[16'h0020] <= 32'h1122_3344;
            mem[16'h0030] <= 32'hCAFE_0030;
            m_rdata       <= 32'h0;
        end else if (m_en) begin
            m_rdata <= mem[m_addr];
            if (m_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_be[b]) mem[m_addr][b*8 +: 8] <= m_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = 16'h0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 16'h0;
        d_wdata = 32'h0; d_lock = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0010; d_addr = 16'h0030;
        #1;
        n_total++; if (i_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_i_gnt got %b exp 0", i_gnt); end
        n_total++; if (d_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_d_gnt got %b exp 0", d_gnt); end
        n_total++; if (m_en !== 1'b0) begin n_bad++; $display("FAIL reset_m_en got %b exp 0", m_en); end
        n_total++; if ({i_rvalid, d_rvalid} !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid got %b exp 00", {i_rvalid, d_rvalid}); end
        n_total++; if (m_addr !== 16'h0) begin n_bad++; $display("FAIL reset_m_addr got %h exp 0000", m_addr); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_fetch_only();
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0010;
        #1;
        n_total++; if ({i_gnt, d_gnt} !== 2'b10) begin n_bad++; $display("FAIL fetch_gnt got %b exp 10", {i_gnt, d_gnt}); end
        n_total++; if ({m_en, m_we, m_be} !== 6'b10_1111) begin n_bad++; $display("FAIL fetch_mctl got %b exp 101111", {m_en, m_we, m_be}); end
        n_total++; if (m_addr !== 16'h0010) begin n_bad++; $display("FAIL fetch_maddr got %h exp 0010", m_addr); end
        n_total++; if (m_wdata !== 32'h0) begin n_bad++; $display("FAIL fetch_mwdata got %h exp 0", m_wdata); end
        @(negedge clk);
        i_req = 1'b0;
        #1;
        n_total++; if (i_rvalid !== 1'b1) begin n_bad++; $display("FAIL fetch_rvalid got %b exp 1", i_rvalid); end
        n_total++; if (i_rdata !== 32'h0000_0013) begin n_bad++; $display("FAIL fetch_rdata got %h exp 00000013", i_rdata); end
        n_total++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL fetch_d_rvalid got %b exp 0", d_rvalid); end
        n_total++; if (m_en !== 1'b0) begin n_bad++; $display("FAIL fetch_idle_m_en got %b exp 0", m_en); end
        @(negedge clk);
        #1;
        n_total++; if (i_rvalid !== 1'b0) begin n_bad++; $display("FAIL fetch_rvalid_pulse got %b exp 0", i_rvalid); end
    endtask

    task automatic test_tie_after_reset();
        logic prev_d;
        prev_d = 1'b0;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            i_req = 1'b1; i_addr = 16'h0010;
            d_req = 1'b1; d_addr = 16'h0030; d_we = 1'b0;
            #1;
            n_total++;
            if ({d_gnt, i_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL tie_gnt[%0d] got d/i=%b%b exp %s", k, d_gnt, i_gnt, (k % 2 == 0) ? "10" : "01");
            end
            if (k > 0) begin
                n_total++;
                if ({d_rvalid, i_rvalid} !== {prev_d, ~prev_d}) begin
                    n_bad++; $display("FAIL tie_rvalid[%0d] got d/i=%b%b exp %b%b", k, d_rvalid, i_rvalid, prev_d, ~prev_d);
                end
                n_total++;
                if (d_rdata !== (prev_d ? 32'hCAFE_0030 : 32'h0000_0013)) begin
                    n_bad++; $display("FAIL tie_rdata[%0d] got %h", k, d_rdata);
                end
            end
            prev_d = (k % 2 == 0);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_total++; if ({d_rvalid, i_rvalid} !== 2'b01) begin n_bad++; $display("FAIL tie_last_rvalid got d/i=%b%b exp 01", d_rvalid, i_rvalid); end
        n_total++; if (i_rdata !== 32'h0000_0013) begin n_bad++; $display("FAIL tie_last_rdata got %h exp 00000013", i_rdata); end
    endtask

    task automatic test_byte_write();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 16'h0020; d_wdata = 32'h0000_AB00;
        #1;
        n_total++; if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL bw_gnt got %b exp 1", d_gnt); end
        n_total++; if ({m_we, m_be} !== 5'b1_0010) begin n_bad++; $display("FAIL bw_mctl got %b exp 10010", {m_we, m_be}); end
        n_total++; if (m_wdata !== 32'h0000_AB00) begin n_bad++; $display("FAIL bw_mwdata got %h exp 0000ab00", m_wdata); end
        @(negedge clk);
        d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0;
        #1;
        n_total++; if (d_rvalid !== 1'b1) begin n_bad++; $display("FAIL bw_ack got %b exp 1", d_rvalid); end
        n_total++; if ({d_gnt, m_we} !== 2'b10) begin n_bad++; $display("FAIL bw_read_gnt got %b exp 10", {d_gnt, m_we}); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_total++; if (d_rvalid !== 1'b1) begin n_bad++; $display("FAIL bw_read_rvalid got %b exp 1", d_rvalid); end
        n_total++; if (d_rdata !== 32'h1122_AB44) begin n_bad++; $display("FAIL bw_read_rdata got %h exp 1122ab44", d_rdata); end
    endtask

    task automatic test_lock();
        apply_reset();
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_lock = 1'b1; d_addr = 16'h0030; d_we = 1'b0;
        #1;
        n_total++; if ({d_gnt, i_gnt} !== 2'b10) begin n_bad++; $display("FAIL lock_first got d/i=%b%b exp 10", d_gnt, i_gnt); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            d_req = 1'b0; d_lock = 1'b0;
            #1;
            n_total++; if ({d_gnt, i_gnt, m_en} !== 3'b000) begin n_bad++; $display("FAIL lock_hold[%0d] got d/i/en=%b%b%b exp 000", c, d_gnt, i_gnt, m_en); end
            n_total++; if (d_rvalid !== (c == 0)) begin n_bad++; $display("FAIL lock_rvalid[%0d] got %b exp %b", c, d_rvalid, (c == 0)); end
        end
        @(negedge clk);
        d_req = 1'b1; d_lock = 1'b0;
        #1;
        n_total++; if ({d_gnt, i_gnt} !== 2'b10) begin n_bad++; $display("FAIL lock_unlock got d/i=%b%b exp 10", d_gnt, i_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        n_total++; if (i_gnt !== 1'b1) begin n_bad++; $display("FAIL lock_fetch_resume got %b exp 1", i_gnt); end
        n_total++; if (d_rvalid !== 1'b1) begin n_bad++; $display("FAIL lock_unlock_rvalid got %b exp 1", d_rvalid); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_total++; if ({i_rvalid, i_rdata} !== {1'b1, 32'h0000_0013}) begin n_bad++; $display("FAIL lock_fetch_rdata got %b/%h exp 1/00000013", i_rvalid, i_rdata); end
    endtask

    task automatic test_reset_mid_read();
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            idle_inputs();
            d_req = 1'b1; d_lock = 1'b1; d_addr = 16'h0030;
            #1;
            n_total++; if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL rmr_gnt[%0d] got %b exp 1", p, d_gnt); end
            #2;
            rst = 1'b0;
            #1;
            n_total++; if ({d_gnt, m_en} !== 2'b00) begin n_bad++; $display("FAIL rmr_forced[%0d] got %b%b exp 00", p, d_gnt, m_en); end
            d_req = 1'b0; d_lock = 1'b0;
            @(negedge clk);
            #1;
            n_total++; if ({d_rvalid, i_rvalid} !== 2'b00) begin n_bad++; $display("FAIL rmr_dropped[%0d] got %b%b exp 00", p, d_rvalid, i_rvalid); end
            @(negedge clk);
            rst = 1'b1;
            i_req = 1'b1; i_addr = 16'h0010;
            d_req = (p == 0); d_addr = 16'h0030;
            #1;
            n_total++; if ({d_rvalid, i_rvalid} !== 2'b00) begin n_bad++; $display("FAIL rmr_release_rvalid[%0d] got %b%b exp 00", p, d_rvalid, i_rvalid); end
            n_total++;
            if ({d_gnt, i_gnt} !== ((p == 0) ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL rmr_after[%0d] got d/i=%b%b exp %s", p, d_gnt, i_gnt, (p == 0) ? "10" : "01");
            end
            @(negedge clk);
            idle_inputs();
            #1;
            n_total++;
            if ((p == 0) ? (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE_0030) : (i_rvalid !== 1'b1 || i_rdata !== 32'h0000_0013)) begin
                n_bad++; $display("FAIL rmr_resp[%0d] got d=%b i=%b data=%h", p, d_rvalid, i_rvalid, m_rdata);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_fetch_only();
        test_tie_after_reset();
        test_byte_write();
        test_lock();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single-port synchronous memory between the instruction-fetch requester (read-only) and the load/store requester (read/write, byte strobes).
- Sits between the core pipeline and the memory array; the memory is the sole consumer of the m_* port.
- Fair round-robin arbitration, one request accepted per cycle, responses routed back by owner one cycle later.
- Lock support so the data side can hold the memory across a read-modify-write sequence.

Parameters:
- ADDR_W, 16, word address width (memory depth 2^ADDR_W words).
- DATA_W, 32, data word width; byte-strobe width is DATA_W/8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request valid; held until i_gnt.
- i_addr  in  ADDR_W  fetch word address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request valid; held until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  DATA_W/8  write byte enables.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_lock  in  1  keep ownership after this request.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response: read data valid, or write acknowledge.
- d_rdata  out  DATA_W  data read data.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_be  out  DATA_W/8  memory byte enables.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid the cycle after m_en.

Behaviour:
- Reset (rst=0, asynchronous):
  - last_owner=FETCH, so data wins the first tie.
  - lock_held=0; resp_owner=NONE.
  - i_rvalid=0, d_rvalid=0.
  - i_gnt=d_gnt=m_en=0 (forced while rst=0).
- Grant is combinational, same cycle as the request; at most one of i_gnt/d_gnt is high.
- Arbitration, evaluated in order:
  - lock_held=1: only d may be granted; i_req stalls.
  - Else exactly one requester: grant it.
  - Else both requesting: grant the one that is not last_owner.
- last_owner updates on every grant.
- Memory drive:
  - m_en = i_gnt | d_gnt.
  - Fetch grant: m_we=0, m_be=all ones, m_addr=i_addr, m_wdata=0.
  - Data grant: m_we=d_we, m_be=d_be, m_addr=d_addr, m_wdata=d_wdata.
  - No grant: m_* are zero.
- Response:
  - resp_owner registers the granted owner (NONE if no grant).
  - Next cycle, the matching *_rvalid pulses for exactly one cycle. Read-to-response latency is 1; back-to-back grants produce back-to-back responses.
  - i_rdata and d_rdata pass m_rdata through; contents are valid only while the matching rvalid is high.
  - A data write returns d_rvalid with d_rdata don't-care.
- Lock:
  - lock_held sets on a d grant with d_lock=1.
  - lock_held clears on a d grant with d_lock=0.
  - While held with d_req=0, no grant occurs and fetch waits.
- Requester changing addr/data before its grant: not permitted; the arbiter samples the value in the grant cycle.
- Reset mid-transaction: the pending response is dropped (rvalid stays 0) and lock is released.

Decomposition:
- Shared package core_pkg:
  - Owner encoding (NONE=2'd0, FETCH=2'd1, DATA=2'd2).
  - ADDR_W/DATA_W defaults.
- Sub-module rr_pick2: two-input round-robin picker (reqs, last_owner, lock → grant one-hot). Pure combinational, reusable for a future DMA port.
- Grant registers, lock, and response routing stay in the top block.

Test Plan:
- Fetch only: i_req=1, i_addr=0x0010, mem[0x10]=0x00000013 → i_gnt same cycle; i_rvalid=1, i_rdata=0x00000013 next cycle; d_rvalid stays 0.
- Tie right after reset: i_req=d_req=1 for 4 cycles → grant order D,I,D,I; rvalid pulses follow one cycle later in the same order.
- Byte write then read: d write addr 0x20, d_be=4'b0010, wdata=0x0000AB00 over mem=0x11223344 → d_rvalid ack, then read returns 0x1122AB44.
- Lock: d_lock=1 on the first access, i_req held high, d idle for 2 cycles, then d access with d_lock=0 → i_gnt stays 0 through all of it, then fires the cycle after the unlocking d grant.
- Async reset mid-read: rst low between d_gnt and the response → d_rvalid never pulses, lock_held=0, and the first tie after release goes to D.
